// File: rtl/slfifo_tx_drain.sv
// rtl/slfifo_tx_drain.sv - drains the staging FIFO onto an FX3-style slave-FIFO write bus
// Two-stage pop/write pipeline under flaga/flagb_n flow control, with idle-timeout short-packet commit.
module slfifo_tx_drain #(
    parameter int DATA_W       = 32,
    parameter int PKT_WORDS    = 256,
    parameter int IDLE_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic              fifo_clk,
    input  logic              reset_,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              read_busy,
    input  logic              flaga,
    input  logic              flagb_n,
    output logic [DATA_W-1:0] fd,
    output logic              slwr_n,
    output logic              pktend_n,
    output logic              busy,
    output logic [31:0]       word_count,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam int PW_W = $clog2(PKT_WORDS + 1);
    localparam int TM_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_PKTEND = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_v;
    logic [DATA_W-1:0]  r_fd;
    logic               r_slwr_n;
    logic               r_pktend_n;
    logic [31:0]        r_word_count;
    logic [CNT_W-1:0]   r_pkt_count;
    logic [PW_W-1:0]    r_pkt_words;
    logic [TM_W-1:0]    r_idle_timer;

    logic               w_read;
    logic               w_partial;
    logic               w_pkt_wrap;
    logic               w_timer_run;
    logic               w_timer_expire;
    logic               w_enter_pktend;

    assign w_partial      = (r_pkt_words != '0);
    assign w_pkt_wrap     = (r_pkt_words == PW_W'(PKT_WORDS - 1));
    // A read in the would-be expiry cycle drops w_timer_run, so the read wins.
    assign w_timer_run    = (r_state == S_STREAM) && !w_read && !r_v && w_partial;
    assign w_timer_expire = w_timer_run && (r_idle_timer == TM_W'(IDLE_TIMEOUT - 1));
    assign w_enter_pktend = (w_next_state == S_PKTEND);

    always_ff @(posedge fifo_clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!enable) begin
                    if (r_v) begin
                        w_next_state = S_DRAIN;
                    end else if (w_partial) begin
                        w_next_state = S_PKTEND;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else if (w_timer_expire) begin
                    w_next_state = S_PKTEND;
                end
            end
            // The last in-flight word has just been counted, so r_pkt_words is final here.
            S_DRAIN: begin
                w_next_state = w_partial ? S_PKTEND : S_IDLE;
            end
            S_PKTEND: begin
                w_next_state = enable ? S_STREAM : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_read = 1'b0;
        busy   = 1'b0;
        if (r_state == S_STREAM) begin
            w_read = !fifo_empty && flaga && flagb_n && enable;
        end
        if (r_state != S_IDLE) begin
            busy = 1'b1;
        end
    end

    always_ff @(posedge fifo_clk or negedge reset_) begin
        if (!reset_) begin
            r_v          <= 1'b0;
            r_fd         <= '0;
            r_slwr_n     <= 1'b1;
            r_pktend_n   <= 1'b1;
            r_word_count <= '0;
            r_pkt_count  <= '0;
            r_pkt_words  <= '0;
            r_idle_timer <= '0;
        end else begin
            r_v        <= w_read;
            r_slwr_n   <= !r_v;
            r_pktend_n <= !w_enter_pktend;
            if (r_v) begin
                r_fd         <= fifo_dout;
                r_word_count <= r_word_count + 32'd1;
            end
            if (w_enter_pktend) begin
                r_pkt_words <= '0;
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end else if (r_v) begin
                if (w_pkt_wrap) begin
                    r_pkt_words <= '0;
                    r_pkt_count <= r_pkt_count + CNT_W'(1);
                end else begin
                    r_pkt_words <= r_pkt_words + PW_W'(1);
                end
            end
            if (w_timer_run && !w_timer_expire) begin
                r_idle_timer <= r_idle_timer + TM_W'(1);
            end else begin
                r_idle_timer <= '0;
            end
        end
    end

    assign read_busy  = w_read;
    assign fd         = r_fd;
    assign slwr_n     = r_slwr_n;
    assign pktend_n   = r_pktend_n;
    assign word_count = r_word_count;
    assign pkt_count  = r_pkt_count;

endmodule
